// File: rtl/cmd_uart_tx.sv
// rtl/cmd_uart_tx.sv - 16-bit command serializer: two 8N1 UART frames, high byte first
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   cmd      in   [15:0] command word, captured when send_cmd is accepted
//   send_cmd in   one-cycle transmit request, honoured only when idle
//   TX       out  registered serial line, idle high
//   busy     out  command in flight
//   cmd_sent out  level, last command fully shifted out; cleared by next accept

module cmd_uart_tx #(
    parameter int BAUD_CYCLES = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);

    localparam int CW = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic           byte_sel_q, byte_sel_d;   // 0: high byte, 1: low byte
    logic [7:0]     shift_q, shift_d;
    logic [15:0]    hold_q, hold_d;
    logic           tx_q, tx_d;
    logic           sent_q, sent_d;

    logic           bit_wrap;
    logic [7:0]     cur_byte;

    assign bit_wrap = (baud_q == BAUD_LAST);
    // Byte for the frame in progress; the shift register is refreshed from
    // the hold register as each data phase begins.
    assign cur_byte = byte_sel_q ? hold_q[7:0] : hold_q[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_sel_q <= 1'b0;
            shift_q    <= '0;
            hold_q     <= '0;
            tx_q       <= 1'b1;
            sent_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            sent_q     <= sent_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        tx_d       = tx_q;
        sent_d     = sent_q;

        if (state_q != IDLE) begin
            baud_d = bit_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (send_cmd) begin
                    hold_d     = cmd;
                    shift_d    = cmd[15:8];
                    byte_sel_d = 1'b0;
                    bit_d      = '0;
                    sent_d     = 1'b0;
                    tx_d       = 1'b0;      // start bit appears the next cycle
                    state_d    = START;
                end
            end
            START: begin
                if (bit_wrap) begin
                    shift_d = cur_byte;
                    tx_d    = cur_byte[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_wrap) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_wrap) begin
                    if (!byte_sel_q) begin
                        // Low byte follows immediately, no idle gap.
                        shift_d    = hold_q[7:0];
                        byte_sel_d = 1'b1;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else begin
                        byte_sel_d = 1'b0;
                        sent_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign TX       = tx_q;
    assign busy     = (state_q != IDLE);
    assign cmd_sent = sent_q;

endmodule

// File: tb/tb_cmd_uart_tx.sv
// tb/tb_cmd_uart_tx.sv - bench for cmd_uart_tx at BAUD_CYCLES 16 and 2

module tb_cmd_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send_i [2];
    logic [15:0] cmd_i  [2];
    logic        tx_o   [2];
    logic        busy_o [2];
    logic        sent_o [2];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cmd_uart_tx #(.BAUD_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst), .cmd(cmd_i[0]), .send_cmd(send_i[0]),
        .TX(tx_o[0]), .busy(busy_o[0]), .cmd_sent(sent_o[0])
    );

    cmd_uart_tx #(.BAUD_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .cmd(cmd_i[1]), .send_cmd(send_i[1]),
        .TX(tx_o[1]), .busy(busy_o[1]), .cmd_sent(sent_o[1])
    );

    function automatic int baud_of(input int i);
        return (i == 0) ? 16 : 2;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is "cycle k since acceptance"; the line
    // value follows from which of the 20 bit slots k falls into.
    bit          m_act  [2];
    int          m_k    [2];
    logic [15:0] m_hold [2];
    bit          m_sent [2];

    function automatic logic exp_tx(input logic [15:0] h, input int k, input int b);
        int bit_no;
        int pos;
        logic [7:0] byt;
        bit_no = k / b;
        pos    = bit_no % 10;
        byt    = (bit_no < 10) ? h[15:8] : h[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos-1];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i]  <= 1'b0;
                m_sent[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (m_k[i] + 1 == 20 * baud_of(i)) begin
                    m_act[i]  <= 1'b0;
                    m_sent[i] <= 1'b1;
                end else begin
                    m_k[i] <= m_k[i] + 1;
                end
            end else if (send_i[i]) begin
                m_act[i]  <= 1'b1;
                m_k[i]    <= 0;
                m_hold[i] <= cmd_i[i];
                m_sent[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic etx, eb, es;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                etx = 1'b1; eb = 1'b0; es = 1'b0;
            end else if (m_act[i]) begin
                etx = exp_tx(m_hold[i], m_k[i], baud_of(i)); eb = 1'b1; es = 1'b0;
            end else begin
                etx = 1'b1; eb = 1'b0; es = m_sent[i];
            end
            chk("tx", i, 32'(tx_o[i]), 32'(etx));
            chk("busy", i, 32'(busy_o[i]), 32'(eb));
            chk("cmd_sent", i, 32'(sent_o[i]), 32'(es));
        end
    end

    // Samples the line mid-bit for 20 bit slots and counts busy cycles.
    // intr_at: cycle at which an ignored 16'hFFFF request is injected.
    // chain: request next_c on the first cycle after cmd_sent rises.
    task automatic capture(input int idx, input logic [15:0] c, input bit do_pulse,
                           input int intr_at, input bit chain, input logic [15:0] next_c,
                           output logic [19:0] vec, output int busy_n);
        int b;
        int last;
        b      = baud_of(idx);
        vec    = '0;
        busy_n = 0;
        if (do_pulse) begin
            @(posedge clk); #2;
            cmd_i[idx]  = c;
            send_i[idx] = 1'b1;
        end
        @(posedge clk); #2;
        send_i[idx] = 1'b0;
        last = chain ? 20 * b : 20 * b + 3;
        for (int cc = 0; cc <= last; cc++) begin
            @(negedge clk);
            if ((cc % b == b / 2) && (cc < 20 * b)) vec = {vec[18:0], tx_o[idx]};
            if (busy_o[idx]) busy_n++;
            if (cc == 20 * b - 1) chk("sent_before_end", idx, 32'(sent_o[idx]), 32'd0);
            if (cc == 20 * b)     chk("sent_at_end", idx, 32'(sent_o[idx]), 32'd1);
            if (cc == intr_at) begin
                cmd_i[idx]  = 16'hFFFF;
                send_i[idx] = 1'b1;
            end
            if (cc == intr_at + 1) send_i[idx] = 1'b0;
            if (chain && cc == 20 * b) begin
                cmd_i[idx]  = next_c;
                send_i[idx] = 1'b1;
            end
        end
    endtask

    initial begin
        logic [19:0] vec;
        int          bn;
        send_i[0] = 1'b0; send_i[1] = 1'b0;
        cmd_i[0]  = '0;   cmd_i[1]  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        capture(0, 16'hA5C3, 1'b1, -5, 1'b0, 16'h0, vec, bn);
        chk("a5c3_frames", 0, 32'(vec), 32'(20'b0101001011_0110000111));
        chk("a5c3_busy", 0, 32'(bn), 32'd320);

        capture(0, 16'h1234, 1'b1, 40, 1'b0, 16'h0, vec, bn);
        chk("1234_ignore_frames", 0, 32'(vec), 32'(20'b0010010001_0001011001));
        chk("1234_busy", 0, 32'(bn), 32'd320);

        @(posedge clk); #2;
        cmd_i[0] = 16'hBEEF; send_i[0] = 1'b1;
        @(posedge clk); #2;
        send_i[0] = 1'b0;
        repeat (64) @(posedge clk);
        #2;
        chk("busy_before_rst", 0, 32'(busy_o[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_tx", 0, 32'(tx_o[0]), 32'd1);
        chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rst_sent", 0, 32'(sent_o[0]), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        capture(0, 16'h00FF, 1'b1, -5, 1'b0, 16'h0, vec, bn);
        chk("00ff_frames", 0, 32'(vec), 32'(20'b0000000001_0111111111));
        chk("00ff_busy", 0, 32'(bn), 32'd320);

        capture(0, 16'h0001, 1'b1, -5, 1'b1, 16'h8000, vec, bn);
        chk("0001_frames", 0, 32'(vec), 32'(20'b0000000001_0100000001));
        capture(0, 16'h8000, 1'b0, -5, 1'b0, 16'h0, vec, bn);
        chk("8000_frames", 0, 32'(vec), 32'(20'b0000000011_0000000001));
        chk("8000_busy", 0, 32'(bn), 32'd320);

        capture(1, 16'h5A5A, 1'b1, -5, 1'b0, 16'h0, vec, bn);
        chk("5a5a_frames", 1, 32'(vec), 32'(20'b0010110101_0010110101));
        chk("5a5a_busy", 1, 32'(bn), 32'd40);

        for (int n = 0; n < 6000; n++) begin
            @(posedge clk); #2;
            send_i[0] = ($urandom_range(0, 29) == 0);
            cmd_i[0]  = 16'($urandom);
            send_i[1] = ($urandom_range(0, 7) == 0);
            cmd_i[1]  = 16'($urandom);
            rst       = ($urandom_range(0, 1499) == 0);
        end
        @(posedge clk); #2;
        send_i[0] = 1'b0; send_i[1] = 1'b0; rst = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cmd_uart_tx.md
Name: cmd_uart_tx

Overview:
- Host-side counterpart of the command processor's UART receive path.
- Accepts a 16-bit follower command and serializes it onto a single UART TX line as two 8N1 frames: high byte first, then low byte.
- This is the byte order the command receiver reassembles into its 16-bit cmd.
- Used in the system testbench and in the remote-control bridge to drive the robot's RX pin.

Parameters:
- BAUD_CYCLES, 2604: clk cycles per UART bit (50 MHz / 19200 baud); legal range 2 to 4095.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous active-high reset
- cmd  input  16  command word; sampled only when send_cmd is accepted
- send_cmd  input  1  single-cycle request to transmit cmd
- TX  output  1  serial line; idle high
- busy  output  1  high while a command is in flight
- cmd_sent  output  1  high when the last command has fully completed

Behaviour:
- Reset (asynchronous, active-high):
  - TX=1, busy=0, cmd_sent=0.
  - State=IDLE; baud counter, bit counter, byte select and shift register all cleared.
  - Reset mid-frame aborts the transfer immediately; no partial frame resumes after reset.
- Accept:
  - send_cmd is accepted only in IDLE.
  - On acceptance, latch cmd into a 16-bit hold register, load shift register with cmd[15:8], set busy=1, clear cmd_sent.
  - send_cmd while busy is ignored; the hold register is unchanged.
- Latency: TX is registered and drives the start bit (0) on the first cycle after the acceptance edge.
- Frame format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit is held exactly BAUD_CYCLES clocks.
  - Baud counter counts 0..BAUD_CYCLES-1 and wraps; a shift occurs on the wrap cycle.
- State machine: IDLE -> START -> DATA -> STOP.
  - START: TX=0 for one bit period -> DATA.
  - DATA: TX=shift[0]; shift right on each bit wrap. Bit counter 0..7; after the 8th bit -> STOP.
  - STOP: TX=1 for one bit period.
    - If byte select = high byte: load cmd_hold[7:0], toggle byte select, -> START. No idle gap between frames.
    - If byte select = low byte: -> IDLE, busy=0, cmd_sent=1.
- Total transfer time: 20*BAUD_CYCLES cycles from the first start-bit cycle to cmd_sent rising.
- cmd_sent:
  - Level signal; stays high until the next accepted send_cmd or reset.
  - If send_cmd is asserted in the same cycle cmd_sent rises, it is ignored, because the state is not yet IDLE.
- busy and cmd_sent are never high simultaneously.
- Counter widths: the baud counter is sized by $clog2(BAUD_CYCLES); there is no overflow beyond terminal count.
- In IDLE, TX=1 continuously.

Test Plan:
- BAUD_CYCLES=16, cmd=16'hA5C3, pulse send_cmd -> TX sequence per 16 cycles:
  - Frame 1: 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first).
  - Frame 2: 0,1,1,0,0,0,0,1,1,1 (0xC3).
  - busy high for 320 cycles; cmd_sent rises at cycle 320 after the start bit.
- While busy sending 16'h1234, pulse send_cmd with cmd=16'hFFFF -> the line still carries 0x12 then 0x34; busy is not extended; no second transfer occurs.
- Assert rst during DATA of the high byte -> TX=1, busy=0, cmd_sent=0 in the same cycle. After release, a send_cmd with 16'h00FF transmits cleanly: frames 0x00 then 0xFF.
- Back-to-back: pulse send_cmd the first cycle after cmd_sent rises, with 16'h0001 then 16'h8000:
  - cmd_sent drops on acceptance.
  - Frames decode as 0x00, 0x01, 0x80, 0x00.
  - Only a single idle-high cycle separates the two commands.
- BAUD_CYCLES=2, cmd=16'h5A5A -> each bit is held exactly 2 cycles; total busy time is 40 cycles; the decoded bytes are 0x5A, 0x5A.
- Loopback into UART_wrapper with the same BAUD: send 16'h0003 -> the receiver's cmd=16'h0003 and cmd_rdy pulses after the stop bit of the low byte.
